// File: rtl/vga_sprite_layer.sv
// Sprite overlay: per-frame clamped motion, priority hit test, 2-stage colour-key merge.
// Define SPRITE_COLLISION_EN to build the per-frame sprite overlap flag.
module vga_sprite_layer #(
   parameter int NUM_SPRITES = 4,
   parameter int SPRITE_W    = 50,
   parameter int SPRITE_H    = 50,
   parameter int SCREEN_W    = 640,
   parameter int SCREEN_H    = 480,
   parameter int COLOR_BITS  = 12,
   parameter int STEP        = 1,
   parameter logic [COLOR_BITS-1:0] KEY_COLOR = '0,
   parameter int ROM_AW      = 16
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [9:0]               x,
   input  logic [8:0]               y,
   input  logic                     active,
   input  logic                     screen_end,
   input  logic [COLOR_BITS-1:0]    bg_color,
   input  logic [NUM_SPRITES-1:0]   mv_left,
   input  logic [NUM_SPRITES-1:0]   mv_right,
   input  logic [NUM_SPRITES-1:0]   mv_up,
   input  logic [NUM_SPRITES-1:0]   mv_down,
   output logic [ROM_AW-1:0]        rom_addr,
   input  logic [COLOR_BITS-1:0]    rom_data,
   output logic [COLOR_BITS-1:0]    color_out,
   output logic [10*NUM_SPRITES-1:0] pos_x,
   output logic [9*NUM_SPRITES-1:0] pos_y,
   output logic                     collision
);

   localparam int IW = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1;
   localparam logic signed [10:0] XMAX  = 11'(SCREEN_W - SPRITE_W);
   localparam logic signed [10:0] YMAX  = 11'(SCREEN_H - SPRITE_H);
   localparam logic signed [10:0] SSTEP = 11'(STEP);

   logic [9:0]         r_px [NUM_SPRITES];
   logic [8:0]         r_py [NUM_SPRITES];
   logic [9:0]         w_nx [NUM_SPRITES];
   logic [8:0]         w_ny [NUM_SPRITES];
   logic signed [10:0] w_tx [NUM_SPRITES];
   logic signed [10:0] w_ty [NUM_SPRITES];
   logic               r_se_d;
   logic               w_frame;

   assign w_frame = screen_end & ~r_se_d;

   always_comb begin
      for (int i = 0; i < NUM_SPRITES; i++) begin
         w_tx[i] = $signed({1'b0, r_px[i]});
         w_ty[i] = $signed({2'b00, r_py[i]});
         if (mv_right[i] & ~mv_left[i])
            w_tx[i] = w_tx[i] + SSTEP;
         else if (mv_left[i] & ~mv_right[i])
            w_tx[i] = w_tx[i] - SSTEP;
         if (mv_down[i] & ~mv_up[i])
            w_ty[i] = w_ty[i] + SSTEP;
         else if (mv_up[i] & ~mv_down[i])
            w_ty[i] = w_ty[i] - SSTEP;
         if (w_tx[i] < 11'sd1)      w_nx[i] = 10'd1;
         else if (w_tx[i] > XMAX)   w_nx[i] = XMAX[9:0];
         else                       w_nx[i] = w_tx[i][9:0];
         if (w_ty[i] < 11'sd1)      w_ny[i] = 9'd1;
         else if (w_ty[i] > YMAX)   w_ny[i] = YMAX[8:0];
         else                       w_ny[i] = w_ty[i][8:0];
      end
   end

   // Edge register resets high so a release during screen_end never moves sprites
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_se_d <= 1'b1;
         for (int i = 0; i < NUM_SPRITES; i++) begin
            r_px[i] <= 10'(1 + i * SPRITE_W);
            r_py[i] <= 9'd1;
         end
      end else begin
         r_se_d <= screen_end;
         if (w_frame) begin
            for (int i = 0; i < NUM_SPRITES; i++) begin
               r_px[i] <= w_nx[i];
               r_py[i] <= w_ny[i];
            end
         end
      end
   end

   always_comb begin
      pos_x = '0;
      pos_y = '0;
      for (int i = 0; i < NUM_SPRITES; i++) begin
         pos_x[10*i +: 10] = r_px[i];
         pos_y[9*i +: 9]   = r_py[i];
      end
   end

   logic [NUM_SPRITES-1:0] w_hit;
   logic [IW-1:0]          w_idx;
   logic [9:0]             w_dx;
   logic [8:0]             w_dy;
   logic [ROM_AW-1:0]      w_addr;

   always_comb begin
      w_hit = '0;
      w_idx = '0;
      for (int i = 0; i < NUM_SPRITES; i++) begin
         w_hit[i] = (x >= r_px[i])
                  & ({1'b0, x} < ({1'b0, r_px[i]} + 11'(SPRITE_W)))
                  & (y >= r_py[i])
                  & ({1'b0, y} < ({1'b0, r_py[i]} + 10'(SPRITE_H)));
      end
      // Scan downwards so the lowest hit index wins
      for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
         if (w_hit[i]) w_idx = IW'(i);
      end
      w_dx   = x - r_px[w_idx];
      w_dy   = y - r_py[w_idx];
      w_addr = ROM_AW'(w_idx) * ROM_AW'(SPRITE_W * SPRITE_H)
             + ROM_AW'(w_dy) * ROM_AW'(SPRITE_W)
             + ROM_AW'(w_dx);
   end

   logic [ROM_AW-1:0]     r_rom_addr;
   logic                  r_hit_d;
   logic                  r_act_d;
   logic [COLOR_BITS-1:0] r_bg_d;
   logic [COLOR_BITS-1:0] r_color;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_rom_addr <= '0;
         r_hit_d    <= 1'b0;
         r_act_d    <= 1'b0;
         r_bg_d     <= '0;
         r_color    <= '0;
      end else begin
         if (|w_hit) r_rom_addr <= w_addr;
         r_hit_d <= |w_hit;
         r_act_d <= active;
         r_bg_d  <= bg_color;
         if (!r_act_d)
            r_color <= '0;
         else if (r_hit_d && (rom_data != KEY_COLOR))
            r_color <= rom_data;
         else
            r_color <= r_bg_d;
      end
   end

   assign rom_addr  = r_rom_addr;
   assign color_out = r_color;

`ifdef SPRITE_COLLISION_EN
   logic r_sticky;
   logic r_coll;
   logic w_multi;

   // More than one bit set iff clearing the lowest set bit leaves something
   assign w_multi = |(w_hit & (w_hit - NUM_SPRITES'(1)));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_sticky <= 1'b0;
         r_coll   <= 1'b0;
      end else if (w_frame) begin
         r_coll   <= r_sticky;
         r_sticky <= 1'b0;
      end else if (active && w_multi) begin
         r_sticky <= 1'b1;
      end
   end

   assign collision = r_coll;
`else
   assign collision = 1'b0;
`endif

endmodule

// File: tb/tb_vga_sprite_layer.sv
// Scoreboard bench for vga_sprite_layer: random pixels and moves vs a
// behavioural frame/pixel model; a negedge monitor retires due expectations.
module tb_vga_sprite_layer;

   localparam int NS = 4;
   localparam int SW = 50;
   localparam int SH = 50;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic [9:0]    x = '0;
   logic [8:0]    y = '0;
   logic          active = 1'b0;
   logic          screen_end = 1'b1;
   logic [11:0]   bg_color = '0;
   logic [NS-1:0] mv_left = '0;
   logic [NS-1:0] mv_right = '0;
   logic [NS-1:0] mv_up = '0;
   logic [NS-1:0] mv_down = '0;
   logic [15:0]   rom_addr;
   logic [11:0]   rom_data;
   logic [11:0]   color_out;
   logic [39:0]   pos_x;
   logic [35:0]   pos_y;
   logic          collision;

   vga_sprite_layer dut (
      .clk(clk), .reset(reset), .x(x), .y(y),
      .active(active), .screen_end(screen_end),
      .bg_color(bg_color),
      .mv_left(mv_left), .mv_right(mv_right),
      .mv_up(mv_up), .mv_down(mv_down),
      .rom_addr(rom_addr), .rom_data(rom_data),
      .color_out(color_out),
      .pos_x(pos_x), .pos_y(pos_y),
      .collision(collision)
   );

   always #5 clk = ~clk;

   function automatic logic [11:0] rom_fn(input logic [15:0] a);
      if (a % 16'd5 == 16'd0) return 12'h000;
      return a[11:0] | 12'h001;
   endfunction

   assign rom_data = rom_fn(rom_addr);

   typedef struct {
      int          kind;
      int          due;
      logic [75:0] exp;
   } chk_t;

   chk_t sb[$];
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;
   int   mx[NS];
   int   my[NS];
   bit   frame_flag = 0;
   bit   last_coll = 0;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic void push(input int k, input int d, input logic [75:0] e);
      chk_t c;
      c.kind = k;
      c.due  = d;
      c.exp  = e;
      sb.push_back(c);
   endfunction

   function automatic logic [75:0] pack_pos();
      logic [39:0] px;
      logic [35:0] py;
      for (int i = 0; i < NS; i++) begin
         px[10*i +: 10] = 10'(mx[i]);
         py[9*i +: 9]   = 9'(my[i]);
      end
      return {px, py};
   endfunction

   function automatic string kname(input int k);
      case (k)
         0: return "rom_addr";
         1: return "color_out";
         2: return "positions";
         3: return "collision";
         default: return "pos_x0";
      endcase
   endfunction

   always @(negedge clk) begin
      int i;
      logic [75:0] act;
      i = 0;
      while (i < sb.size()) begin
         if (sb[i].due == cyc) begin
            case (sb[i].kind)
               0: act = 76'(rom_addr);
               1: act = 76'(color_out);
               2: act = {pos_x, pos_y};
               3: act = 76'(collision);
               default: act = 76'(pos_x[9:0]);
            endcase
            checks++;
            if (act !== sb[i].exp) begin
               errors++;
               $display("FAIL %s cyc=%0d got=%0h want=%0h",
                        kname(sb[i].kind), cyc, act, sb[i].exp);
            end
            sb.delete(i);
         end else if (sb[i].due < cyc) begin
            checks++;
            errors++;
            $display("FAIL %s missed due=%0d cyc=%0d",
                     kname(sb[i].kind), sb[i].due, cyc);
            sb.delete(i);
         end else begin
            i++;
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic model_reset();
      for (int i = 0; i < NS; i++) begin
         mx[i] = 1 + i * SW;
         my[i] = 1;
      end
      frame_flag = 0;
      last_coll  = 0;
   endtask

   task automatic pix(input int px, input int py, input bit act);
      logic [11:0] bg;
      logic [11:0] col;
      int w, cnt, a;
      bg = 12'($urandom);
      x = 10'(px);
      y = 9'(py);
      active = act;
      bg_color = bg;
      w = -1;
      cnt = 0;
      for (int i = 0; i < NS; i++) begin
         if (px >= mx[i] && px < mx[i] + SW && py >= my[i] && py < my[i] + SH) begin
            cnt++;
            if (w < 0) w = i;
         end
      end
      a = (w < 0) ? 0 : w * SW * SH + (py - my[w]) * SW + (px - mx[w]);
      if (!act) col = 12'h000;
      else if (w >= 0 && rom_fn(16'(a)) != 12'h000) col = rom_fn(16'(a));
      else col = bg;
      if (act && w >= 0) push(0, cyc + 1, 76'(a));
      push(1, cyc + 2, 76'(col));
      if (act && cnt >= 2) frame_flag = 1;
   endtask

   task automatic rand_pix(input bit act);
      int s, px, py;
      if ($urandom_range(0, 3) == 0) begin
         px = int'($urandom_range(0, 639));
         py = int'($urandom_range(0, 479));
      end else begin
         s  = int'($urandom_range(0, NS - 1));
         px = mx[s] + int'($urandom_range(0, 59)) - 5;
         py = my[s] + int'($urandom_range(0, 59)) - 5;
         if (px < 0) px = 0;
         if (px > 639) px = 639;
         if (py < 0) py = 0;
         if (py > 479) py = 479;
      end
      pix(px, py, act);
   endtask

   task automatic frame(input int npix, input logic [NS-1:0] l,
                        input logic [NS-1:0] r, input logic [NS-1:0] u,
                        input logic [NS-1:0] d);
      int dx, dy;
      push(3, cyc + 1, 76'(last_coll));
      repeat (npix) begin
         rand_pix($urandom_range(0, 7) != 0);
         step();
      end
      screen_end = 1'b1;
      mv_left = l;
      mv_right = r;
      mv_up = u;
      mv_down = d;
      rand_pix(1'b0);
      for (int i = 0; i < NS; i++) begin
         dx = (r[i] && !l[i]) ? 1 : (l[i] && !r[i]) ? -1 : 0;
         dy = (d[i] && !u[i]) ? 1 : (u[i] && !d[i]) ? -1 : 0;
         mx[i] = mx[i] + dx;
         my[i] = my[i] + dy;
         if (mx[i] < 1) mx[i] = 1;
         if (mx[i] > 640 - SW) mx[i] = 640 - SW;
         if (my[i] < 1) my[i] = 1;
         if (my[i] > 480 - SH) my[i] = 480 - SH;
      end
`ifdef SPRITE_COLLISION_EN
      last_coll = frame_flag;
`else
      last_coll = 0;
`endif
      frame_flag = 0;
      push(2, cyc + 1, pack_pos());
      push(3, cyc + 1, 76'(last_coll));
      step();
      rand_pix(1'b0);
      step();
      screen_end = 1'b0;
      mv_left = '0;
      mv_right = '0;
      mv_up = '0;
      mv_down = '0;
   endtask

   initial begin
      model_reset();
      #1 reset = 1'b1;
      repeat (3) step();
      push(1, cyc, 76'(0));
      push(0, cyc, 76'(0));
      push(2, cyc, pack_pos());
      push(3, cyc, 76'(0));
      step();
      mv_right = '1;
      mv_down = '1;
      reset = 1'b0;
      repeat (3) step();
      push(2, cyc, pack_pos());
      push(4, cyc, 76'(1));
      step();
      mv_right = '0;
      mv_down = '0;
      screen_end = 1'b0;
      step();

      pix(10, 10, 1'b1);
      push(0, cyc + 1, 76'(459));
      step();
      pix(6, 1, 1'b1);
      step();
      pix(10, 10, 1'b0);
      step();

      repeat (3) frame(6, 4'b0000, 4'b0001, 4'b0000, 4'b0000);
      push(4, cyc, 76'(4));
      frame(6, 4'b0001, 4'b0001, 4'b0000, 4'b0000);
      push(4, cyc, 76'(4));
      frame(6, 4'b0000, 4'b0000, 4'b0001, 4'b0000);

      repeat (20) frame(8, 4'($urandom), 4'($urandom),
                        4'($urandom), 4'($urandom));

      repeat (600) begin
         logic [1:0] rb;
         rb = 2'($urandom);
         frame(6, {1'b1, rb[0], 1'b1, 1'b0},
                  {1'b1, rb[1], 1'b0, 1'b1},
                  {rb[0], rb[1], 1'b1, 1'b0},
                  {rb[1], rb[0], 1'b0, 1'b1});
      end
      push(4, cyc, 76'(590));
      step();

      repeat (3) begin
         pix(mx[0] + 5, my[0] + 5, 1'b1);
         step();
      end
      #2 reset = 1'b1;
      #1;
      checks++;
      if (color_out !== 12'h000) begin
         errors++;
         $display("FAIL async_reset_color got=%0h want=0", color_out);
      end
      checks++;
      if (rom_addr !== 16'h0000) begin
         errors++;
         $display("FAIL async_reset_addr got=%0h want=0", rom_addr);
      end
      sb.delete();
      model_reset();
      screen_end = 1'b1;
      active = 1'b0;
      step();
      step();
      reset = 1'b0;
      step();
      push(2, cyc, pack_pos());
      step();
      screen_end = 1'b0;
      step();

      repeat (5) frame(10, 4'($urandom), 4'($urandom),
                       4'($urandom), 4'($urandom));

      repeat (4) step();
      if (sb.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL scoreboard_drain left=%0d want=0", sb.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
